// File: rtl/coin_collect_scheduler.sv
// Per-frame coin pickup scheduler: holds the level's coin table and scans one slot per cycle
// against Mario's tile-aligned hitbox, retiring touched coins and driving the coin counter.
module coin_collect_scheduler #(
  parameter int NUM_COINS       = 8,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int HITBOX_INSET    = 10,
  parameter int COIN_WRAP       = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [10:0]                  mario_x,
  input  logic [10:0]                  mario_y,
  input  logic                         load_valid,
  input  logic [$clog2(NUM_COINS)-1:0] load_idx,
  input  logic [4:0]                   load_x,
  input  logic [4:0]                   load_y,
  input  logic                         level_clear,
  output logic                         busy,
  output logic                         done,
  output logic                         collect_valid,
  output logic [4:0]                   collect_x,
  output logic [4:0]                   collect_y,
  output logic [6:0]                   coin_count,
  output logic                         extra_life,
  output logic [NUM_COINS-1:0]         active_mask,
  output logic [1:0]                   dbg_state
);

  localparam int IW = $clog2(NUM_COINS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0]        r_idx;
  logic [4:0]           r_l;
  logic [4:0]           r_r;
  logic [4:0]           r_t;
  logic [4:0]           r_b;
  logic [4:0]           r_slot_x [NUM_COINS];
  logic [4:0]           r_slot_y [NUM_COINS];
  logic [NUM_COINS-1:0] r_active;
  logic                 r_collect_valid;
  logic [4:0]           r_collect_x;
  logic [4:0]           r_collect_y;
  logic [6:0]           r_coin_count;
  logic                 r_extra_life;

  logic [11:0] w_x_ext;
  logic [11:0] w_y_ext;
  logic [4:0]  w_l;
  logic [4:0]  w_r;
  logic [4:0]  w_t;
  logic [4:0]  w_b;
  logic [4:0]  w_cur_x;
  logic [4:0]  w_cur_y;
  logic        w_hit;
  logic        w_load_ok;

  // Hitbox corners to tile indices; 12-bit sums cannot overflow for on-screen positions.
  assign w_x_ext = {1'b0, mario_x};
  assign w_y_ext = {1'b0, mario_y};
  assign w_l = 5'((w_x_ext + 12'(HITBOX_INSET)) / 12'(BLOCK_WIDTH));
  assign w_r = 5'((w_x_ext + 12'(CHARACTER_WIDTH - HITBOX_INSET)) / 12'(BLOCK_WIDTH));
  assign w_t = 5'((w_y_ext + 12'(HITBOX_INSET)) / 12'(BLOCK_WIDTH));
  assign w_b = 5'((w_y_ext + 12'(CHARACTER_WIDTH - HITBOX_INSET)) / 12'(BLOCK_WIDTH));

  // Single shared compare datapath: the slot under r_idx is the only one examined this cycle.
  assign w_cur_x = r_slot_x[r_idx];
  assign w_cur_y = r_slot_y[r_idx];
  assign w_hit   = (r_state == S_SCAN) && r_active[r_idx] && !level_clear &&
                   ((w_cur_x == r_l) || (w_cur_x == r_r)) &&
                   ((w_cur_y == r_t) || (w_cur_y == r_b));

  // load_valid has no ready: a write is taken on any edge where busy=0 and level_clear=0,
  // otherwise it is dropped; the producer must watch busy.
  assign w_load_ok = load_valid && (r_state == S_IDLE) && !level_clear;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_SCAN;
      S_SCAN:  if (r_idx == IW'(NUM_COINS - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (level_clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_t     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_LATCH) begin
        r_l   <= w_l;
        r_r   <= w_r;
        r_t   <= w_t;
        r_b   <= w_b;
        r_idx <= '0;
      end else if (r_state == S_SCAN) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= '0;
      for (int i = 0; i < NUM_COINS; i++) begin
        r_slot_x[i] <= '0;
        r_slot_y[i] <= '0;
      end
    end else if (level_clear) begin
      r_active <= '0;
    end else begin
      if (w_load_ok) begin
        r_active[load_idx] <= 1'b1;
        r_slot_x[load_idx] <= load_x;
        r_slot_y[load_idx] <= load_y;
      end
      if (w_hit) r_active[r_idx] <= 1'b0;
    end
  end

  // Collect pulse, counter and wrap pulse all land on the same edge as the retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collect_valid <= 1'b0;
      r_collect_x     <= '0;
      r_collect_y     <= '0;
      r_coin_count    <= '0;
      r_extra_life    <= 1'b0;
    end else begin
      r_collect_valid <= w_hit;
      r_extra_life    <= 1'b0;
      if (w_hit) begin
        r_collect_x <= w_cur_x;
        r_collect_y <= w_cur_y;
        if (r_coin_count == 7'(COIN_WRAP - 1)) begin
          r_coin_count <= '0;
          r_extra_life <= 1'b1;
        end else begin
          r_coin_count <= r_coin_count + 7'd1;
        end
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign collect_valid = r_collect_valid;
  assign collect_x     = r_collect_x;
  assign collect_y     = r_collect_y;
  assign coin_count    = r_coin_count;
  assign extra_life    = r_extra_life;
  assign active_mask   = r_active;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_coin_collect_scheduler.sv
// Directed bench for coin_collect_scheduler: table of whole-frame vectors plus hand-written
// sequences for ignored inputs, level_clear mid-scan, counter wrap and asynchronous reset.
module tb_coin_collect_scheduler;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [10:0] mario_x;
  logic [10:0] mario_y;
  logic        load_valid;
  logic [2:0]  load_idx;
  logic [4:0]  load_x;
  logic [4:0]  load_y;
  logic        level_clear;
  logic        busy;
  logic        done;
  logic        collect_valid;
  logic [4:0]  collect_x;
  logic [4:0]  collect_y;
  logic [6:0]  coin_count;
  logic        extra_life;
  logic [7:0]  active_mask;
  logic [1:0]  dbg_state;

  coin_collect_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .mario_x       (mario_x),
    .mario_y       (mario_y),
    .load_valid    (load_valid),
    .load_idx      (load_idx),
    .load_x        (load_x),
    .load_y        (load_y),
    .level_clear   (level_clear),
    .busy          (busy),
    .done          (done),
    .collect_valid (collect_valid),
    .collect_x     (collect_x),
    .collect_y     (collect_y),
    .coin_count    (coin_count),
    .extra_life    (extra_life),
    .active_mask   (active_mask),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        la_en;
    logic [2:0]  la_idx;
    logic [4:0]  la_x;
    logic [4:0]  la_y;
    logic        lb_en;
    logic [2:0]  lb_idx;
    logic [4:0]  lb_x;
    logic [4:0]  lb_y;
    logic [10:0] mx;
    logic [10:0] my;
    int          hit_a;
    logic [4:0]  ha_x;
    logic [4:0]  ha_y;
    int          hit_b;
    logic [4:0]  hb_x;
    logic [4:0]  hb_y;
    logic [6:0]  exp_cnt;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q [$];

  logic       obs_cv   [0:31];
  logic       obs_done [0:31];
  logic       obs_busy [0:31];
  logic       obs_el   [0:31];
  logic [6:0] obs_cnt  [0:31];
  logic [7:0] obs_mask [0:31];
  int         n_done;

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver tasks; each returns 1 time unit after a rising edge
  task automatic load_slot(input logic [2:0] idx, input logic [4:0] x, input logic [4:0] y);
    load_valid = 1'b1;
    load_idx   = idx;
    load_x     = x;
    load_y     = y;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check($sformatf("load_visible_slot%0d", idx), 32'(active_mask[idx]), 32'd1);
  endtask

  task automatic run_frame(input logic [10:0] mx, input logic [10:0] my, input int ncyc,
                           input int fs_cyc, input int ld_cyc, input logic [2:0] ld_idx,
                           input logic [4:0] ld_x, input logic [4:0] ld_y, input int clr_cyc);
    logic [9:0] e;
    int n_exp;
    int n_seen;
    n_exp       = exp_q.size();
    n_seen      = 0;
    n_done      = 0;
    mario_x     = mx;
    mario_y     = my;
    frame_start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      obs_cv[c]   = collect_valid;
      obs_done[c] = done;
      obs_busy[c] = busy;
      obs_el[c]   = extra_life;
      obs_cnt[c]  = coin_count;
      obs_mask[c] = active_mask;
      if (done) n_done++;
      if (collect_valid) begin
        n_seen++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("collect_xy_c%0d", c), {22'd0, collect_x, collect_y}, {22'd0, e});
        end
      end
      frame_start = (c == fs_cyc);
      load_valid  = (c == ld_cyc);
      load_idx    = ld_idx;
      load_x      = ld_x;
      load_y      = ld_y;
      level_clear = (c == clr_cyc);
    end
    frame_start = 1'b0;
    load_valid  = 1'b0;
    level_clear = 1'b0;
    check("collect_count", n_seen, n_exp);
    exp_q.delete();
  endtask

  initial begin
    int remaining;
    int n;

    vecs[0] = '{1'b1, 3'd0, 5'd10, 5'd5,  1'b0, 3'd0, 5'd0,  5'd0,  11'd400, 11'd200,
                3,  5'd10, 5'd5,  0, 5'd0,  5'd0, 7'd1, 8'h00};
    vecs[1] = '{1'b1, 3'd2, 5'd9,  5'd5,  1'b1, 3'd3, 5'd10, 5'd5,  11'd385, 11'd195,
                5,  5'd9,  5'd5,  6, 5'd10, 5'd5, 7'd3, 8'h00};
    vecs[2] = '{1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 3'd0, 5'd0,  5'd0,  11'd385, 11'd195,
                0,  5'd0,  5'd0,  0, 5'd0,  5'd0, 7'd3, 8'h00};
    vecs[3] = '{1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 3'd0, 5'd0,  5'd0,  11'd400, 11'd200,
                0,  5'd0,  5'd0,  0, 5'd0,  5'd0, 7'd3, 8'h00};
    vecs[4] = '{1'b1, 3'd7, 5'd0,  5'd0,  1'b1, 3'd1, 5'd3,  5'd2,  11'd0,   11'd0,
                10, 5'd0,  5'd0,  0, 5'd0,  5'd0, 7'd4, 8'h02};
    vecs[5] = '{1'b1, 3'd4, 5'd1,  5'd1,  1'b1, 3'd5, 5'd0,  5'd2,  11'd20,  11'd20,
                7,  5'd1,  5'd1,  0, 5'd0,  5'd0, 7'd5, 8'h22};
    vecs[6] = '{1'b1, 3'd6, 5'd16, 5'd12, 1'b0, 3'd0, 5'd0,  5'd0,  11'd639, 11'd479,
                9,  5'd16, 5'd12, 0, 5'd0,  5'd0, 7'd6, 8'h22};

    reset       = 1'b0;
    frame_start = 1'b0;
    mario_x     = '0;
    mario_y     = '0;
    load_valid  = 1'b0;
    load_idx    = '0;
    load_x      = '0;
    load_y      = '0;
    level_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cv", 32'(collect_valid), 0);
    check("rst_cx", 32'(collect_x), 0);
    check("rst_cy", 32'(collect_y), 0);
    check("rst_cnt", 32'(coin_count), 0);
    check("rst_el", 32'(extra_life), 0);
    check("rst_mask", 32'(active_mask), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 0);

    // table-driven whole-frame vectors
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].la_en) load_slot(vecs[v].la_idx, vecs[v].la_x, vecs[v].la_y);
      if (vecs[v].lb_en) load_slot(vecs[v].lb_idx, vecs[v].lb_x, vecs[v].lb_y);
      if (vecs[v].hit_a != 0) exp_q.push_back({vecs[v].ha_x, vecs[v].ha_y});
      if (vecs[v].hit_b != 0) exp_q.push_back({vecs[v].hb_x, vecs[v].hb_y});
      run_frame(vecs[v].mx, vecs[v].my, 14, 0, 0, 3'd0, 5'd0, 5'd0, 0);
      for (int c = 1; c <= 14; c++) begin
        check($sformatf("v%0d_cv_c%0d", v, c), 32'(obs_cv[c]),
              32'((c == vecs[v].hit_a) || (c == vecs[v].hit_b)));
        check($sformatf("v%0d_done_c%0d", v, c), 32'(obs_done[c]), 32'(c == 10));
        check($sformatf("v%0d_busy_c%0d", v, c), 32'(obs_busy[c]), 32'(c <= 10));
        check($sformatf("v%0d_el_c%0d", v, c), 32'(obs_el[c]), 0);
      end
      if (vecs[v].hit_a != 0)
        check($sformatf("v%0d_cnt_at_hit_a", v), 32'(obs_cnt[vecs[v].hit_a]),
              32'(vecs[v].exp_cnt) - 32'(vecs[v].hit_b != 0));
      if (vecs[v].hit_b != 0)
        check($sformatf("v%0d_cnt_at_hit_b", v), 32'(obs_cnt[vecs[v].hit_b]),
              32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_cnt", v), 32'(obs_cnt[14]), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_mask", v), 32'(obs_mask[14]), 32'(vecs[v].exp_mask));
    end

    // frame_start and load_valid at cycle 4 of a scan are both dropped
    run_frame(11'd400, 11'd200, 16, 4, 4, 3'd0, 5'd10, 5'd5, 0);
    check("ign_done_pulses", n_done, 1);
    check("ign_mask", 32'(obs_mask[16]), 32'h22);
    check("ign_cnt", 32'(obs_cnt[16]), 6);
    for (int c = 11; c <= 16; c++)
      check($sformatf("ign_idle_c%0d", c), 32'(obs_busy[c]), 0);

    // level_clear while slot 5 is a hit under evaluation
    run_frame(11'd0, 11'd70, 14, 0, 0, 3'd0, 5'd0, 5'd0, 7);
    check("clr_busy_before", 32'(obs_busy[7]), 1);
    check("clr_mask_before", 32'(obs_mask[7]), 32'h22);
    check("clr_mask", 32'(obs_mask[8]), 0);
    check("clr_busy", 32'(obs_busy[8]), 0);
    check("clr_cv", 32'(obs_cv[8]), 0);
    check("clr_no_done", n_done, 0);
    check("clr_cnt", 32'(obs_cnt[14]), 6);

    // drive the counter up to 99
    remaining = 93;
    while (remaining > 0) begin
      n = (remaining > 8) ? 8 : remaining;
      for (int i = 0; i < n; i++) begin
        load_slot(3'(i), 5'd10, 5'd5);
        exp_q.push_back({5'd10, 5'd5});
      end
      run_frame(11'd400, 11'd200, 12, 0, 0, 3'd0, 5'd0, 5'd0, 0);
      remaining -= n;
    end
    check("preload_cnt", 32'(coin_count), 99);

    // wrap: 99 -> 0 with extra_life alongside collect_valid
    load_slot(3'd3, 5'd10, 5'd5);
    exp_q.push_back({5'd10, 5'd5});
    run_frame(11'd400, 11'd200, 14, 0, 0, 3'd0, 5'd0, 5'd0, 0);
    check("wrap_cnt_before", 32'(obs_cnt[5]), 99);
    check("wrap_cv", 32'(obs_cv[6]), 1);
    check("wrap_el", 32'(obs_el[6]), 1);
    check("wrap_cnt", 32'(obs_cnt[6]), 0);
    for (int c = 1; c <= 14; c++)
      if (c != 6) check($sformatf("wrap_el_quiet_c%0d", c), 32'(obs_el[c]), 0);

    // asynchronous reset in the middle of a scan
    load_slot(3'd0, 5'd10, 5'd5);
    load_slot(3'd4, 5'd20, 5'd20);
    mario_x     = 11'd400;
    mario_y     = 11'd200;
    frame_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (c == 3) check("ar_cv_c3", 32'(collect_valid), 1);
    end
    check("ar_busy_before", 32'(busy), 1);
    check("ar_cnt_before", 32'(coin_count), 1);
    check("ar_cx_before", 32'(collect_x), 10);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_done", 32'(done), 0);
    check("ar_cv", 32'(collect_valid), 0);
    check("ar_cx", 32'(collect_x), 0);
    check("ar_cy", 32'(collect_y), 0);
    check("ar_cnt", 32'(coin_count), 0);
    check("ar_el", 32'(extra_life), 0);
    check("ar_mask", 32'(active_mask), 0);
    check("ar_state", 32'(dbg_state), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ar_after_busy", 32'(busy), 0);
    check("ar_after_mask", 32'(active_mask), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
